pllcfg_cmd_sequencer: RTL
=========================

Name: pllcfg_cmd_sequencer

Overview:
- Upstream producer of the 3-bit command word read by the NIOS on its PLLCFG command PIO input (`in_port[2:0]`).
- Takes host-side PLL request levels from the SPI/FPGA-config register domain, synchronises them into `clk` and edge-detects them.
- Queues the requests and presents one encoded command at a time to the NIOS, holding it until the NIOS firmware acknowledges via a PIO output.
- Returns busy/done/error status to the host register map.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per host request input (legal values 2..4).
- TIMEOUT_CYCLES, 16777216, clk cycles allowed in WAIT_ACK before a timeout is declared; 0 disables the timeout.
- TMR_W, 25, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, same domain as the NIOS and its PIOs.
- reset_n  in  1  asynchronous active-low reset.
- req_pllcfg  in  1  host request for PLL reconfiguration; async level, rising edge = request.
- req_pllrst  in  1  host request for PLL reset; async level, rising edge = request.
- req_phcfg  in  1  host request for phase-shift configuration; async level, rising edge = request.
- cmd_ack  in  1  NIOS PIO output, synchronous to clk; high = command consumed.
- cmd_err  in  1  NIOS PIO output, synchronous to clk; sampled in the same cycle cmd_ack is first seen high.
- cmd_code  out  3  command to the NIOS PIO: 0 idle, 1 PLLRST, 2 PLLCFG, 3 PHCFG; 4-7 unused.
- busy  out  1  high while state is not IDLE.
- done  out  1  last command acknowledged without error; sticky.
- error  out  1  last command ended with cmd_err or a timeout; sticky.
- timeout  out  1  last command ended by timeout; sticky.

Behaviour:
- Reset is asynchronous and active-low on reset_n, clock is clk.
- Reset values:
  - cmd_code=0, busy=0, done=0, error=0, timeout=0.
  - Synchroniser and edge flops =0; pending[2:0]=0; timer=0; state=IDLE.
- Request input path:
  - Each req_* passes through SYNC_STAGES flops, then one edge flop.
  - A rising edge sets the matching pending bit SYNC_STAGES+1 cycles after the input transition.
  - A request input held high produces exactly one request.
  - An input that is high when reset is released does not produce a request (edge flop resets to 0, synchroniser to 0; the first rising edge seen after reset is taken only if the input went 0→1).
- Pending bits:
  - One bit per command type. A repeated request while that bit is already set is merged (no count).
  - Clearing a bit on issue and setting it from a new edge in the same cycle leaves the bit set.
- FSM states are IDLE, WAIT_ACK and WAIT_REL.
- IDLE:
  - If pending≠0, select the highest-priority bit: PLLRST > PLLCFG > PHCFG.
  - In that cycle: drive cmd_code with the selected code (visible next cycle), clear that pending bit, clear done/error/timeout, set timer=0, go to WAIT_ACK.
  - cmd_ack high while in IDLE is ignored.
- WAIT_ACK:
  - timer increments each cycle.
  - If cmd_ack=1: cmd_code←0; done←~cmd_err; error←cmd_err; go to WAIT_REL.
  - Else if TIMEOUT_CYCLES≠0 and timer==TIMEOUT_CYCLES-1: cmd_code←0; error←1; timeout←1; done←0; go to WAIT_REL.
  - cmd_ack has priority over a timeout occurring in the same cycle.
- WAIT_REL:
  - Stay until cmd_ack=0, then go to IDLE (four-phase handshake).
  - A new command cannot issue earlier than 1 cycle after cmd_ack falls.
- busy is a registered (state≠IDLE) and rises the same cycle cmd_code becomes non-zero.
- New requests arriving in any state only set pending bits. A request for the command currently executing is re-executed after completion.
- cmd_code only changes on an IDLE→WAIT_ACK transition (to the new code) or on a WAIT_ACK exit (to 0). It is never changed mid-handshake.
- Reset asserted mid-operation: everything returns to reset values immediately; pending requests are discarded.

Test Plan:
- Reset released with all req low; pulse req_pllcfg 0→1 → with SYNC_STAGES=2, pending set 3 cycles later, cmd_code=2 and busy=1 one cycle after; assert cmd_ack 5 cycles later → next cycle cmd_code=0, done=1, error=0; drop cmd_ack → busy=0 one cycle later.
- Raise req_phcfg, req_pllrst and req_pllcfg in the same cycle → commands issue in order 1, 2, 3, each only after the previous cmd_ack falls; pending=0 at end.
- During WAIT_ACK of cmd 2, toggle req_pllcfg twice more → exactly one further cmd 2 is issued after release (merge).
- TIMEOUT_CYCLES=8, no cmd_ack → cmd_code returns to 0 exactly 8 cycles after entering WAIT_ACK; error=1, timeout=1, done=0; the next request clears all three flags on issue.
- cmd_ack=1 with cmd_err=1 → error=1, done=0, timeout=0. Separately, cmd_ack first high exactly on the timeout cycle → ack wins, timeout=0.
- Assert reset_n low while in WAIT_ACK with two requests pending → cmd_code=0, busy=0, all flags 0 asynchronously; after release no command issues until a new rising edge arrives.

Source files
------------

// File: rtl/pllcfg_cmd_sequencer.sv
// PLLCFG command sequencer: synchronises host PLL request levels, queues them and
// hands one command at a time to the NIOS PIO with a four-phase ack handshake.
module pllcfg_cmd_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 16777216,
    parameter int TMR_W          = 25
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_pllcfg,
    input  logic       req_pllrst,
    input  logic       req_phcfg,
    input  logic       cmd_ack,
    input  logic       cmd_err,
    output logic [2:0] cmd_code,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_WAIT_REL = 2'd2
    } state_t;

    localparam logic [2:0]       CODE_IDLE   = 3'd0;
    localparam logic [2:0]       CODE_PLLRST = 3'd1;
    localparam logic [2:0]       CODE_PLLCFG = 3'd2;
    localparam logic [2:0]       CODE_PHCFG  = 3'd3;
    localparam bit               TMO_EN      = (TIMEOUT_CYCLES != 0);
    localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);

    // Request bit order everywhere: [0] PLLRST, [1] PLLCFG, [2] PHCFG.
    logic [2:0]                  w_req;
    logic [2:0][SYNC_STAGES-1:0] r_sync;
    logic [2:0]                  r_edge;
    logic [2:0]                  r_armed;
    logic [SYNC_STAGES-1:0]      r_fill;
    logic [2:0]                  w_sync_last;
    logic [2:0]                  w_rise;

    assign w_req = {req_phcfg, req_pllcfg, req_pllrst};

    always_comb begin
        w_sync_last = '0;
        for (int i = 0; i < 3; i++) w_sync_last[i] = r_sync[i][SYNC_STAGES-1];
    end

    // A path is armed only once it has synchronised a genuine post-reset low, so a
    // level already high at reset release is never mistaken for a new request.
    assign w_rise = w_sync_last & ~r_edge & r_armed;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= '0;
            r_edge  <= '0;
            r_armed <= '0;
            r_fill  <= '0;
        end else begin
            for (int i = 0; i < 3; i++) r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_req[i]};
            r_edge <= w_sync_last;
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            if (r_fill[SYNC_STAGES-1]) r_armed <= r_armed | ~w_sync_last;
        end
    end

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_pending, w_clr;
    logic [2:0]       r_cmd_code, w_code_nxt;
    logic [TMR_W-1:0] r_timer, w_timer_nxt;
    logic             r_busy, r_done, r_error, r_timeout;
    logic             w_done_nxt, w_error_nxt, w_timeout_nxt;
    logic [2:0]       w_sel_code, w_sel_mask;

    always_comb begin
        w_sel_code = CODE_IDLE;
        w_sel_mask = 3'b000;
        if (r_pending[0]) begin
            w_sel_code = CODE_PLLRST;
            w_sel_mask = 3'b001;
        end else if (r_pending[1]) begin
            w_sel_code = CODE_PLLCFG;
            w_sel_mask = 3'b010;
        end else if (r_pending[2]) begin
            w_sel_code = CODE_PHCFG;
            w_sel_mask = 3'b100;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_code_nxt    = r_cmd_code;
        w_timer_nxt   = r_timer;
        w_done_nxt    = r_done;
        w_error_nxt   = r_error;
        w_timeout_nxt = r_timeout;
        w_clr         = 3'b000;
        unique case (r_state)
            ST_IDLE: begin
                if (|r_pending) begin
                    w_code_nxt    = w_sel_code;
                    w_clr         = w_sel_mask;
                    w_done_nxt    = 1'b0;
                    w_error_nxt   = 1'b0;
                    w_timeout_nxt = 1'b0;
                    w_timer_nxt   = '0;
                    w_state_nxt   = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                w_timer_nxt = r_timer + 1'b1;
                if (cmd_ack) begin
                    w_code_nxt  = CODE_IDLE;
                    w_done_nxt  = ~cmd_err;
                    w_error_nxt = cmd_err;
                    w_state_nxt = ST_WAIT_REL;
                end else if (TMO_EN && (r_timer == TMO_LAST)) begin
                    w_code_nxt    = CODE_IDLE;
                    w_done_nxt    = 1'b0;
                    w_error_nxt   = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_WAIT_REL;
                end
            end
            ST_WAIT_REL: begin
                if (!cmd_ack) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_pending  <= '0;
            r_cmd_code <= CODE_IDLE;
            r_timer    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= (r_pending & ~w_clr) | w_rise;
            r_cmd_code <= w_code_nxt;
            r_timer    <= w_timer_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign cmd_code = r_cmd_code;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign timeout  = r_timeout;

endmodule
